// File: rtl/dma_xfer_engine.sv
// dma_xfer_engine: single-channel DMA master that copies LEN words (read one, write it) src -> dst.
// Optional feature macro DMA_ABORT_EN adds an abort input that stops the transfer after the current strobe.
module dma_xfer_engine #(
  parameter int LEN_W     = 16,
  parameter int ADDR_STEP = 4,
  parameter int RD_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
`ifdef DMA_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_done,
  output logic             rd_en,
  output logic             wr_en,
  output logic [31:0]      addr,
  output logic [31:0]      wdata,
  input  logic [31:0]      rdata
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, FIN} state_t;

  localparam logic [31:0]      STEP      = 32'(ADDR_STEP);
  localparam logic [2:0]       LAST_WAIT = 3'(RD_LAT - 1);
  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

  state_t           state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [31:0]      data_reg;
  logic [LEN_W-1:0] remaining;
  logic [2:0]       wait_cnt;
  logic             abort_req;

`ifdef DMA_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Write data is only driven during the write strobe so the bus idles at zero.
  assign wdata = wr_en ? data_reg : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      wr_en      <= 1'b0;
      addr       <= 32'd0;
      words_done <= '0;
      src_ptr    <= 32'd0;
      dst_ptr    <= 32'd0;
      data_reg   <= 32'd0;
      remaining  <= '0;
      wait_cnt   <= 3'd0;
    end else begin
      // NOTE: non-blocking defaults make every strobe a single-cycle pulse unless a state re-asserts it.
      done  <= 1'b0;
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      addr  <= 32'd0;

      case (state)
        IDLE: begin
          if (start) begin
            words_done <= '0;
            if (len != '0) begin
              src_ptr   <= src_addr;
              dst_ptr   <= dst_addr;
              remaining <= len;
              busy      <= 1'b1;
              rd_en     <= 1'b1;
              addr      <= src_addr;
              state     <= RD;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end

        RD: begin
          wait_cnt <= 3'd0;
          if (abort_req) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (abort_req) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else if (wait_cnt == LAST_WAIT) begin
            data_reg <= rdata;
            wr_en    <= 1'b1;
            addr     <= dst_ptr;
            state    <= WR;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end

        WR: begin
          src_ptr    <= src_ptr + STEP;
          dst_ptr    <= dst_ptr + STEP;
          remaining  <= remaining - ONE;
          words_done <= words_done + ONE;
          if (remaining == ONE || abort_req) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            rd_en <= 1'b1;
            addr  <= src_ptr + STEP;
            state <= RD;
          end
        end

        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
